// File: rtl/mem_ctrl_if.sv
// Requester + RAM/IO bus bundle for mem_ctrl.
// slave: mem_ctrl; master: LSB, fetch unit and RAM/IO side.
interface mem_ctrl_if #(
  parameter int AW = 32
) ();
  logic          lsb_signal;
  logic          lsb_wr;
  logic          lsb_signed;
  logic [1:0]    lsb_len;
  logic [AW-1:0] lsb_addr;
  logic [31:0]   lsb_din;
  logic [31:0]   lsb_dout;
  logic          lsb_done;

  logic          if_signal;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_dout;
  logic          if_done;

  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic          io_buffer_full;

  modport slave (
    input  lsb_signal,
    input  lsb_wr,
    input  lsb_signed,
    input  lsb_len,
    input  lsb_addr,
    input  lsb_din,
    output lsb_dout,
    output lsb_done,
    input  if_signal,
    input  if_addr,
    output if_dout,
    output if_done,
    input  ram_din,
    output ram_dout,
    output ram_a,
    output ram_wr,
    input  io_buffer_full
  );

  modport master (
    output lsb_signal,
    output lsb_wr,
    output lsb_signed,
    output lsb_len,
    output lsb_addr,
    output lsb_din,
    input  lsb_dout,
    input  lsb_done,
    output if_signal,
    output if_addr,
    input  if_dout,
    input  if_done,
    output ram_din,
    input  ram_dout,
    input  ram_a,
    input  ram_wr,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB loads/stores and instruction
// fetch onto a byte-wide RAM/IO bus with sign/zero-extended loads.
module mem_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h30000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_own_if;
  logic [2:0]            r_cnt;
  logic [2:0]            r_n;
  logic                  r_signed;
  logic [1:0]            r_len;
  logic [31:0]           r_din;
  logic [31:0]           r_buf;
  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [7:0]            r_ram_dout;
  logic [31:0]           r_lsb_dout;
  logic [31:0]           r_if_dout;
  logic                  r_lsb_done;
  logic                  r_if_done;

  logic                  w_owner_sig;
  logic                  w_io;
  logic                  w_stall;
  logic                  w_wlast;
  logic                  w_rlast;
  logic                  w_ram_wr;
  logic [2:0]            w_lsb_n;
  logic [1:0]            w_lane;
  logic [31:0]           w_asm;
  logic [31:0]           w_ext;

  assign w_owner_sig = r_own_if ? bus.if_signal
                                : bus.lsb_signal;
  assign w_io    = (r_ram_a >= IO_BASE) &&
                   (r_ram_a <= IO_BASE + ADDR_WIDTH'(7));
  assign w_stall = w_io && bus.io_buffer_full;
  assign w_wlast = (r_cnt == r_n - 3'd1);
  assign w_rlast = (r_cnt == r_n);
  assign w_lane  = r_cnt[1:0] - 2'd1;

  always_comb begin
    unique case (1'b1)
      bus.lsb_len == 2'b00: w_lsb_n = 3'd1;
      bus.lsb_len == 2'b01: w_lsb_n = 3'd2;
      default:              w_lsb_n = 3'd4;
    endcase
  end

  // Byte read in the previous cycle lands in lane cnt-1.
  always_comb begin
    w_asm = r_buf;
    w_asm[{w_lane, 3'b000} +: 8] = bus.ram_din;
  end

  always_comb begin
    unique case (1'b1)
      r_len == 2'b00:
        w_ext = {{24{r_signed & w_asm[7]}}, w_asm[7:0]};
      r_len == 2'b01:
        w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
      default:
        w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (rdy_in) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.lsb_signal) begin
            w_next = bus.lsb_wr ? S_WRITE : S_READ;
          end else if (bus.if_signal) begin
            w_next = S_READ;
          end
        end
        S_READ: begin
          if (!w_owner_sig) begin
            w_next = S_IDLE;
          end else if (w_rlast) begin
            w_next = S_DONE;
          end
        end
        S_WRITE: begin
          if (!w_stall && w_wlast) begin
            w_next = S_DONE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ram_wr = rdy_in && (r_state == S_WRITE) && !w_stall;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_own_if   <= 1'b0;
      r_cnt      <= '0;
      r_n        <= '0;
      r_signed   <= 1'b0;
      r_len      <= '0;
      r_din      <= '0;
      r_buf      <= '0;
      r_ram_a    <= '0;
      r_ram_dout <= '0;
      r_lsb_dout <= '0;
      r_if_dout  <= '0;
      r_lsb_done <= 1'b0;
      r_if_done  <= 1'b0;
    end else if (rdy_in) begin
      r_lsb_done <= 1'b0;
      r_if_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.lsb_signal) begin
            r_own_if   <= 1'b0;
            r_cnt      <= '0;
            r_n        <= w_lsb_n;
            r_signed   <= bus.lsb_signed;
            r_len      <= bus.lsb_len;
            r_buf      <= '0;
            r_ram_a    <= bus.lsb_addr;
            r_ram_dout <= bus.lsb_din[7:0];
            r_din      <= {8'h00, bus.lsb_din[31:8]};
          end else if (bus.if_signal) begin
            r_own_if <= 1'b1;
            r_cnt    <= '0;
            r_n      <= 3'd4;
            r_signed <= 1'b0;
            r_len    <= 2'b11;
            r_buf    <= '0;
            r_ram_a  <= bus.if_addr;
          end
        end
        S_READ: begin
          if (w_owner_sig) begin
            if (r_cnt != 3'd0) begin
              r_buf <= w_asm;
            end
            if (w_rlast) begin
              if (r_own_if) begin
                r_if_dout <= w_asm;
                r_if_done <= 1'b1;
              end else begin
                r_lsb_dout <= w_ext;
                r_lsb_done <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt + 3'd1 < r_n) begin
                r_ram_a <= r_ram_a + ADDR_WIDTH'(1);
              end
            end
          end
        end
        S_WRITE: begin
          if (!w_stall) begin
            if (w_wlast) begin
              r_lsb_done <= 1'b1;
            end else begin
              r_cnt      <= r_cnt + 3'd1;
              r_ram_a    <= r_ram_a + ADDR_WIDTH'(1);
              r_ram_dout <= r_din[7:0];
              r_din      <= {8'h00, r_din[31:8]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_a    = r_ram_a;
  assign bus.ram_dout = r_ram_dout;
  assign bus.ram_wr   = w_ram_wr;
  assign bus.lsb_dout = r_lsb_dout;
  assign bus.lsb_done = r_lsb_done;
  assign bus.if_dout  = r_if_dout;
  assign bus.if_done  = r_if_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random
// loads/stores/fetches against a byte-array reference model.
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  always #5 clk_in = ~clk_in;

  mem_ctrl_if #(.AW(32)) bus ();

  mem_ctrl #(
    .ADDR_WIDTH(32),
    .IO_BASE(32'h30000)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // RAM environment: registered read, one cycle after address.
  logic [7:0] ram [int unsigned];
  always @(posedge clk_in) begin
    if (bus.ram_wr === 1'b1) ram[bus.ram_a] = bus.ram_dout;
    bus.ram_din <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : 8'h00;
  end

  // Reference memory, updated only from intended stores.
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                          input int n, input bit sgn);
    longint v;
    logic [31:0] ai;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v += longint'(ref_byte(ai)) << (8 * i);
    end
    if (sgn && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  function automatic int len_n(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  logic [31:0] o_a [64];
  logic        o_wr [64];
  logic [7:0]  o_do [64];
  int          l_dc, l_np, f_dc, f_np;
  logic [31:0] l_dv, f_dv;
  logic [31:0] exp_ldout = 32'h0;

  // Drives one scenario; cycle k is the interval after accepting edge k.
  task automatic run(input bit do_l, input bit do_f, input bit wr,
                     input bit sgn, input logic [1:0] len,
                     input logic [31:0] la, input logic [31:0] din,
                     input logic [31:0] fa, input int stall,
                     input int rlo, input int rlen, input int drop);
    bit l_on, f_on;
    int last;
    l_on = do_l;
    f_on = do_f;
    bus.lsb_signal = do_l;
    bus.lsb_wr = wr;
    bus.lsb_signed = sgn;
    bus.lsb_len = len;
    bus.lsb_addr = la;
    bus.lsb_din = din;
    bus.if_signal = do_f;
    bus.if_addr = fa;
    bus.io_buffer_full = (stall > 0);
    l_dc = -1; f_dc = -1; l_np = 0; f_np = 0;
    l_dv = '0; f_dv = '0; last = -1;
    for (int k = 0; k < 64; k++) begin
      o_a[k] = '0; o_wr[k] = 1'b0; o_do[k] = '0;
    end
    @(posedge clk_in);
    for (int k = 0; k < 60; k++) begin
      #1;
      bus.io_buffer_full = (k < stall);
      rdy_in = !(k >= rlo && k < rlo + rlen);
      if (k == drop) begin
        bus.lsb_signal = 1'b0;
        l_on = 1'b0;
      end
      #1;
      o_a[k] = bus.ram_a;
      o_wr[k] = bus.ram_wr;
      o_do[k] = bus.ram_dout;
      if (bus.lsb_done === 1'b1) begin
        l_np++;
        if (l_dc < 0) begin
          l_dc = k;
          l_dv = bus.lsb_dout;
        end
        bus.lsb_signal = 1'b0;
        l_on = 1'b0;
      end
      if (bus.if_done === 1'b1) begin
        f_np++;
        if (f_dc < 0) begin
          f_dc = k;
          f_dv = bus.if_dout;
        end
        bus.if_signal = 1'b0;
        f_on = 1'b0;
      end
      if (!l_on && !f_on) begin
        if (last < 0) last = k;
        if (k >= last + 4) break;
      end
      @(posedge clk_in);
    end
    bus.lsb_signal = 1'b0;
    bus.if_signal = 1'b0;
    bus.io_buffer_full = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (bus.ram_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_ram_a got=%h exp=0", bus.ram_a);
    end
    checks++;
    if (bus.ram_dout !== 8'h0) begin
      failures++;
      $display("FAIL reset_ram_dout got=%h exp=0", bus.ram_dout);
    end
    checks++;
    if (bus.lsb_dout !== 32'h0 || bus.if_dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_dout got=%h/%h exp=0/0",
               bus.lsb_dout, bus.if_dout);
    end
    checks++;
    if ({bus.ram_wr, bus.lsb_done, bus.if_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000",
               {bus.ram_wr, bus.lsb_done, bus.if_done});
    end
    rst_in = 1'b1;
  endtask

  task automatic test_word_load;
    logic [31:0] e;
    poke(32'h100, 8'h11);
    poke(32'h101, 8'h22);
    poke(32'h102, 8'h33);
    poke(32'h103, 8'h80);
    e = ref_load(32'h100, 4, 1'b0);
    run(1, 0, 0, 0, 2'b11, 32'h100, 0, 0, 0, 99, 0, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_a[i] !== 32'h100 + 32'(i) || o_wr[i] !== 1'b0) begin
        failures++;
        $display("FAIL wload_addr c%0d got=%h/%b exp=%h/0",
                 i, o_a[i], o_wr[i], 32'h100 + 32'(i));
      end
    end
    checks++;
    if (l_dc !== 5 || l_np !== 1) begin
      failures++;
      $display("FAIL wload_done got=c%0d x%0d exp=c5 x1", l_dc, l_np);
    end
    checks++;
    if (l_dv !== e) begin
      failures++;
      $display("FAIL wload_data got=%h exp=%h", l_dv, e);
    end
    exp_ldout = e;
  endtask

  task automatic test_signed_byte;
    logic [31:0] e;
    poke(32'h200, 8'hF0);
    for (int s = 1; s >= 0; s--) begin
      e = ref_load(32'h200, 1, s[0]);
      run(1, 0, 0, s[0], 2'b00, 32'h200, 0, 0, 0, 99, 0, -1);
      checks++;
      if (l_dc !== 2 || l_dv !== e) begin
        failures++;
        $display("FAIL byte_load s=%0d got=c%0d %h exp=c2 %h",
                 s, l_dc, l_dv, e);
      end
      exp_ldout = e;
    end
    e = ref_load(32'h102, 2, 1'b1);
    run(1, 0, 0, 1, 2'b01, 32'h102, 0, 0, 0, 99, 0, -1);
    checks++;
    if (l_dc !== 3 || l_dv !== e) begin
      failures++;
      $display("FAIL half_load got=c%0d %h exp=c3 %h", l_dc, l_dv, e);
    end
    exp_ldout = e;
  endtask

  task automatic test_half_store;
    poke(32'h302, 8'h5A);
    run(1, 0, 1, 0, 2'b01, 32'h300, 32'hAABBCCDD, 0, 0, 99, 0, -1);
    ref_mem[32'h300] = 8'hDD;
    ref_mem[32'h301] = 8'hCC;
    checks++;
    if (o_a[0] !== 32'h300 || o_do[0] !== 8'hDD || o_wr[0] !== 1'b1) begin
      failures++;
      $display("FAIL hstore_c0 got=%h %h %b exp=300 dd 1",
               o_a[0], o_do[0], o_wr[0]);
    end
    checks++;
    if (o_a[1] !== 32'h301 || o_do[1] !== 8'hCC || o_wr[1] !== 1'b1) begin
      failures++;
      $display("FAIL hstore_c1 got=%h %h %b exp=301 cc 1",
               o_a[1], o_do[1], o_wr[1]);
    end
    checks++;
    if (l_dc !== 2 || o_wr[2] !== 1'b0) begin
      failures++;
      $display("FAIL hstore_done got=c%0d wr2=%b exp=c2 0", l_dc, o_wr[2]);
    end
    checks++;
    if (env_byte(32'h302) !== ref_byte(32'h302) ||
        env_byte(32'h300) !== ref_byte(32'h300)) begin
      failures++;
      $display("FAIL hstore_ram got=%h %h exp=%h %h",
               env_byte(32'h300), env_byte(32'h302),
               ref_byte(32'h300), ref_byte(32'h302));
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] el, ef;
    el = ref_load(32'h100, 4, 1'b0);
    ef = ref_load(32'h300, 4, 1'b0);
    run(1, 1, 0, 0, 2'b11, 32'h100, 0, 32'h300, 0, 99, 0, -1);
    checks++;
    if (l_dc !== 5 || l_np !== 1 || l_dv !== el) begin
      failures++;
      $display("FAIL arb_lsb got=c%0d x%0d %h exp=c5 x1 %h",
               l_dc, l_np, l_dv, el);
    end
    checks++;
    if (o_a[7] !== 32'h300) begin
      failures++;
      $display("FAIL arb_fetch_addr got=%h exp=300", o_a[7]);
    end
    checks++;
    if (f_dc !== 12 || f_np !== 1 || f_dv !== ef) begin
      failures++;
      $display("FAIL arb_fetch got=c%0d x%0d %h exp=c12 x1 %h",
               f_dc, f_np, f_dv, ef);
    end
    exp_ldout = el;
  endtask

  task automatic test_io_stall;
    run(1, 0, 1, 0, 2'b00, 32'h30000, 32'h77, 0, 3, 99, 0, -1);
    ref_mem[32'h30000] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_wr[i] !== 1'b0) begin
        failures++;
        $display("FAIL io_stall c%0d got=%b exp=0", i, o_wr[i]);
      end
    end
    checks++;
    if (o_wr[3] !== 1'b1 || o_a[3] !== 32'h30000 || o_do[3] !== 8'h77) begin
      failures++;
      $display("FAIL io_issue got=%b %h %h exp=1 30000 77",
               o_wr[3], o_a[3], o_do[3]);
    end
    checks++;
    if (l_dc !== 4) begin
      failures++;
      $display("FAIL io_done got=c%0d exp=c4", l_dc);
    end
    run(1, 0, 1, 0, 2'b00, 32'h30007, 32'h01, 0, 2, 99, 0, -1);
    checks++;
    if (l_dc !== 3 || o_wr[1] !== 1'b0) begin
      failures++;
      $display("FAIL io_top got=c%0d wr1=%b exp=c3 0", l_dc, o_wr[1]);
    end
    run(1, 0, 1, 0, 2'b00, 32'h30008, 32'h02, 0, 2, 99, 0, -1);
    checks++;
    if (l_dc !== 1 || o_wr[0] !== 1'b1) begin
      failures++;
      $display("FAIL io_outside got=c%0d wr0=%b exp=c1 1", l_dc, o_wr[0]);
    end
    run(1, 0, 1, 0, 2'b00, 32'h2FFFF, 32'h03, 0, 2, 99, 0, -1);
    checks++;
    if (l_dc !== 1) begin
      failures++;
      $display("FAIL io_below got=c%0d exp=c1", l_dc);
    end
    ref_mem[32'h30007] = 8'h01;
    ref_mem[32'h30008] = 8'h02;
    ref_mem[32'h2FFFF] = 8'h03;
  endtask

  task automatic test_abort;
    logic [31:0] ef;
    ef = ref_load(32'h100, 4, 1'b0);
    run(1, 0, 0, 0, 2'b11, 32'h300, 0, 0, 0, 99, 0, 2);
    checks++;
    if (l_np !== 0) begin
      failures++;
      $display("FAIL abort_done got=x%0d exp=x0", l_np);
    end
    checks++;
    if (bus.lsb_dout !== exp_ldout) begin
      failures++;
      $display("FAIL abort_dout got=%h exp=%h", bus.lsb_dout, exp_ldout);
    end
    run(0, 1, 0, 0, 2'b11, 0, 0, 32'h100, 0, 99, 0, -1);
    checks++;
    if (f_dc !== 5 || f_np !== 1 || f_dv !== ef) begin
      failures++;
      $display("FAIL abort_fetch got=c%0d x%0d %h exp=c5 x1 %h",
               f_dc, f_np, f_dv, ef);
    end
  endtask

  task automatic test_rdy_pause;
    run(1, 0, 1, 0, 2'b01, 32'h400, 32'h0000BEEF, 0, 0, 1, 2, -1);
    ref_mem[32'h400] = 8'hEF;
    ref_mem[32'h401] = 8'hBE;
    checks++;
    if (o_wr[1] !== 1'b0 || o_wr[2] !== 1'b0) begin
      failures++;
      $display("FAIL rdy_hold got=%b%b exp=00", o_wr[1], o_wr[2]);
    end
    checks++;
    if (o_wr[3] !== 1'b1 || o_a[3] !== 32'h401 || o_do[3] !== 8'hBE) begin
      failures++;
      $display("FAIL rdy_resume got=%b %h %h exp=1 401 be",
               o_wr[3], o_a[3], o_do[3]);
    end
    checks++;
    if (l_dc !== 4 || env_byte(32'h400) !== 8'hEF) begin
      failures++;
      $display("FAIL rdy_done got=c%0d %h exp=c4 ef",
               l_dc, env_byte(32'h400));
    end
  endtask

  task automatic test_random;
    logic [1:0]  lens [3];
    logic [1:0]  len;
    logic [31:0] a, d, e, ai;
    int n, op;
    bit sg;
    lens[0] = 2'b00;
    lens[1] = 2'b01;
    lens[2] = 2'b11;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      len = lens[$urandom_range(0, 2)];
      n = len_n(len);
      sg = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else a = 32'h1000 + 32'($urandom_range(0, 31));
      if (op == 0) begin
        run(1, 0, 1, 0, len, a, d, 0, 0, 99, 0, -1);
        for (int i = 0; i < n; i++) begin
          ai = a + 32'(i);
          ref_mem[ai] = 8'((d >> (8 * i)) & 32'hFF);
        end
        checks++;
        if (l_dc !== n || l_np !== 1) begin
          failures++;
          $display("FAIL rnd_store it=%0d got=c%0d x%0d exp=c%0d x1",
                   it, l_dc, l_np, n);
        end
        for (int i = 0; i < n; i++) begin
          ai = a + 32'(i);
          checks++;
          if (env_byte(ai) !== ref_byte(ai)) begin
            failures++;
            $display("FAIL rnd_store_byte a=%h got=%h exp=%h",
                     ai, env_byte(ai), ref_byte(ai));
          end
        end
      end else if (op == 1) begin
        e = ref_load(a, n, sg);
        run(1, 0, 0, sg, len, a, 0, 0, 0, 99, 0, -1);
        checks++;
        if (l_dc !== n + 1 || l_dv !== e) begin
          failures++;
          $display("FAIL rnd_load a=%h len=%b s=%0d got=c%0d %h exp=c%0d %h",
                   a, len, sg, l_dc, l_dv, e, n + 1, e);
        end
      end else begin
        e = ref_load(a, 4, 1'b0);
        run(0, 1, 0, 0, 2'b11, 0, 0, a, 0, 99, 0, -1);
        checks++;
        if (f_dc !== 5 || f_dv !== e) begin
          failures++;
          $display("FAIL rnd_fetch a=%h got=c%0d %h exp=c5 %h",
                   a, f_dc, f_dv, e);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite;
    bus.lsb_signal = 1'b1;
    bus.lsb_wr = 1'b1;
    bus.lsb_signed = 1'b0;
    bus.lsb_len = 2'b11;
    bus.lsb_addr = 32'h600;
    bus.lsb_din = 32'h12345678;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h601) begin
      failures++;
      $display("FAIL midwrite_pre got=%b %h exp=1 601",
               bus.ram_wr, bus.ram_a);
    end
    rst_in = 1'b0;
    #1;
    checks++;
    if (bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0 ||
        bus.ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_ram got=%h %h %b exp=0 0 0",
               bus.ram_a, bus.ram_dout, bus.ram_wr);
    end
    checks++;
    if (bus.lsb_dout !== 32'h0 || bus.if_dout !== 32'h0 ||
        bus.lsb_done !== 1'b0 || bus.if_done !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_out got=%h %h %b %b exp=0 0 0 0",
               bus.lsb_dout, bus.if_dout, bus.lsb_done, bus.if_done);
    end
    bus.lsb_signal = 1'b0;
    #2;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    bus.lsb_signal = 1'b0;
    bus.lsb_wr = 1'b0;
    bus.lsb_signed = 1'b0;
    bus.lsb_len = 2'b00;
    bus.lsb_addr = '0;
    bus.lsb_din = '0;
    bus.if_signal = 1'b0;
    bus.if_addr = '0;
    bus.io_buffer_full = 1'b0;
    test_reset();
    test_word_load();
    test_signed_byte();
    test_half_store();
    test_arbitration();
    test_io_stall();
    test_abort();
    test_rdy_pause();
    test_random();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
